// File: rtl/cus19_dmem_arbiter_pkg.sv
// Shared widths, FSM states and owner IDs for the data memory arbiter.
// No ports; imported by the interface, the address generator and the top.
package cus19_dmem_arbiter_pkg;
  localparam int DM_ADDR_W = 19;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 4;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_CRY
  } owner_t;
endpackage

// File: rtl/cus19_dmem_arbiter_if.sv
// Bundle of CPU, crypto and data memory signals around the arbiter.
// slave = arbiter view; master = environment view (CPU, crypto, memory).
interface cus19_dmem_arbiter_if;
  import cus19_dmem_arbiter_pkg::*;

  logic                 cpu_req_in;
  logic                 cpu_we_in;
  logic [DM_ADDR_W-1:0] cpu_addr_in;
  logic [DATA_W-1:0]    cpu_wr_data_in;
  logic                 cpu_gnt_out;
  logic                 cpu_rvalid_out;
  logic [DATA_W-1:0]    cpu_rd_data_out;

  logic                 cry_req_in;
  logic                 cry_we_in;
  logic [DM_ADDR_W-1:0] cry_addr_in;
  logic [LEN_W-1:0]     cry_len_in;
  logic [DATA_W-1:0]    cry_wr_data_in;
  logic                 cry_gnt_out;
  logic                 cry_beat_out;
  logic [LEN_W-1:0]     cry_beat_idx_out;
  logic                 cry_rvalid_out;
  logic [DATA_W-1:0]    cry_rd_data_out;
  logic                 cry_done_out;

  logic                 dm_en_out;
  logic                 dm_we_out;
  logic [DM_ADDR_W-1:0] dm_addr_out;
  logic [DATA_W-1:0]    dm_wr_data_out;
  logic [DATA_W-1:0]    dm_rd_data_in;

  modport slave (
    input  cpu_req_in, cpu_we_in, cpu_addr_in,
    input  cpu_wr_data_in,
    output cpu_gnt_out, cpu_rvalid_out,
    output cpu_rd_data_out,
    input  cry_req_in, cry_we_in, cry_addr_in,
    input  cry_len_in, cry_wr_data_in,
    output cry_gnt_out, cry_beat_out,
    output cry_beat_idx_out, cry_rvalid_out,
    output cry_rd_data_out, cry_done_out,
    output dm_en_out, dm_we_out, dm_addr_out,
    output dm_wr_data_out,
    input  dm_rd_data_in
  );

  modport master (
    output cpu_req_in, cpu_we_in, cpu_addr_in,
    output cpu_wr_data_in,
    input  cpu_gnt_out, cpu_rvalid_out,
    input  cpu_rd_data_out,
    output cry_req_in, cry_we_in, cry_addr_in,
    output cry_len_in, cry_wr_data_in,
    input  cry_gnt_out, cry_beat_out,
    input  cry_beat_idx_out, cry_rvalid_out,
    input  cry_rd_data_out, cry_done_out,
    input  dm_en_out, dm_we_out, dm_addr_out,
    input  dm_wr_data_out,
    output dm_rd_data_in
  );
endinterface

// File: rtl/cus19_dmem_arbiter_agen.sv
// Crypto burst address generator: captures base/len/dir at grant, counts beats.
// Ports: clk/rst, load (grant), adv (burst beat), base/len/we in; idx/addr/last/dir out.
module cus19_dmem_arbiter_agen
  import cus19_dmem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 adv,
  input  logic [DM_ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]     len,
  input  logic                 we,
  output logic [LEN_W-1:0]     idx,
  output logic [DM_ADDR_W-1:0] addr,
  output logic                 last,
  output logic                 dir
);
  logic [DM_ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     cnt_q;
  logic                 we_q;

  // Beat 0 goes out at grant time, so the counter starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
    end else if (load) begin
      base_q <= base;
      len_q  <= len;
      cnt_q  <= LEN_W'(1);
      we_q   <= we;
    end else if (adv) begin
      cnt_q  <= cnt_q + LEN_W'(1);
    end
  end

  // Adder is DM_ADDR_W wide, so the top of memory wraps to 0.
  assign idx  = cnt_q;
  assign addr = base_q + DM_ADDR_W'(cnt_q);
  assign last = (cnt_q == len_q);
  assign dir  = we_q;
endmodule

// File: rtl/cus19_dmem_arbiter.sv
// Arbitrates the single-port data memory between CPU bytes and crypto bursts.
// Ports: clk_in, rst_in (sync, active high), bus (CPU, crypto, memory sides).
module cus19_dmem_arbiter
  import cus19_dmem_arbiter_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  cus19_dmem_arbiter_if.slave bus
);
  state_t state_q, state_n;
  owner_t own_q, own_n;

  logic cpu_rv_q, cry_rv_q, done_q;

  logic                 cpu_gnt, cry_gnt, beat;
  logic [LEN_W-1:0]     idx;
  logic                 en, we;
  logic [DM_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]    wdata;
  logic                 load, adv, last_beat;

  logic [LEN_W-1:0]     ag_idx;
  logic [DM_ADDR_W-1:0] ag_addr;
  logic                 ag_last, ag_dir;

  cus19_dmem_arbiter_agen u_agen (
    .clk  (clk_in),
    .rst  (rst_in),
    .load (load),
    .adv  (adv),
    .base (bus.cry_addr_in),
    .len  (bus.cry_len_in),
    .we   (bus.cry_we_in),
    .idx  (ag_idx),
    .addr (ag_addr),
    .last (ag_last),
    .dir  (ag_dir)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      own_q    <= OWN_CRY;
      cpu_rv_q <= 1'b0;
      cry_rv_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      own_q    <= own_n;
      cpu_rv_q <= cpu_gnt & ~we;
      cry_rv_q <= beat & ~we;
      done_q   <= beat & last_beat;
    end
  end

  always_comb begin
    state_n   = state_q;
    own_n     = own_q;
    cpu_gnt   = 1'b0;
    cry_gnt   = 1'b0;
    beat      = 1'b0;
    idx       = '0;
    en        = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    load      = 1'b0;
    adv       = 1'b0;
    last_beat = 1'b0;
    // Nothing is issued while reset is held.
    if (!rst_in) begin
      unique case (state_q)
        ST_IDLE: begin
          // On a tie, the requester that did not own the last grant wins.
          cpu_gnt = bus.cpu_req_in &
                    (~bus.cry_req_in | (own_q == OWN_CRY));
          cry_gnt = bus.cry_req_in & ~cpu_gnt;
          if (cpu_gnt) begin
            own_n = OWN_CPU;
            en    = 1'b1;
            we    = bus.cpu_we_in;
            addr  = bus.cpu_addr_in;
            wdata = bus.cpu_wr_data_in;
          end else if (cry_gnt) begin
            own_n     = OWN_CRY;
            beat      = 1'b1;
            load      = 1'b1;
            en        = 1'b1;
            we        = bus.cry_we_in;
            addr      = bus.cry_addr_in;
            wdata     = bus.cry_wr_data_in;
            last_beat = (bus.cry_len_in == '0);
            if (!last_beat) state_n = ST_BURST;
          end
        end
        ST_BURST: begin
          beat      = 1'b1;
          adv       = 1'b1;
          idx       = ag_idx;
          en        = 1'b1;
          we        = ag_dir;
          addr      = ag_addr;
          wdata     = bus.cry_wr_data_in;
          last_beat = ag_last;
          if (ag_last) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_gnt_out      = cpu_gnt;
  assign bus.cpu_rvalid_out   = cpu_rv_q;
  assign bus.cpu_rd_data_out  = cpu_rv_q ? bus.dm_rd_data_in : '0;
  assign bus.cry_gnt_out      = cry_gnt;
  assign bus.cry_beat_out     = beat;
  assign bus.cry_beat_idx_out = idx;
  assign bus.cry_rvalid_out   = cry_rv_q;
  assign bus.cry_rd_data_out  = cry_rv_q ? bus.dm_rd_data_in : '0;
  assign bus.cry_done_out     = done_q;
  assign bus.dm_en_out        = en;
  assign bus.dm_we_out        = we;
  assign bus.dm_addr_out      = addr;
  assign bus.dm_wr_data_out   = wdata;
endmodule
